piso_shift_reg_param: RTL
=========================

Name: piso_shift_reg_param

Overview:
Parametrised parallel-in/serial-out shift register. It is the successor to the fixed 4-bit PISO.
- Adds configurable width and bit order, a valid/ready load handshake, a shift-enable tick for baud pacing, and serial_valid/busy/done status.
- Sits between a parallel word source (FIFO, register file) and a single-wire serial sink.

Parameters:
WIDTH, 8, number of data bits per word (legal range 2..32)
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first
IDLE_LEVEL, 0, value driven on serial_out when no word is being sent

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-low reset; rst=0 sampled on a clk edge resets the block
p  input  WIDTH  parallel data word
load_valid  input  1  source offers word on p
load_ready  output  1  block can accept a word
shift_en  input  1  shift tick; advances to the next bit when high at a clk edge
serial_out  output  1  serial data bit
serial_valid  output  1  serial_out carries a data (or parity) bit
busy  output  1  word in flight
done  output  1  one-cycle pulse after the last bit completes

Behaviour:
- Every register updates only on the rising edge of clk. There is a single clock domain.
- Reset (rst=0 at an edge), from any state including mid-word:
  - state=IDLE, shift register=0, bit counter=0.
  - load_ready=1, serial_out=IDLE_LEVEL, serial_valid=0, busy=0, done=0.
- State IDLE:
  - load_ready=1, busy=0, serial_valid=0, serial_out=IDLE_LEVEL.
  - On load_valid=1 at an edge: capture p, counter=0, go to SHIFT.
- State SHIFT:
  - load_ready=0, busy=1, serial_valid=1.
  - serial_out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]; driven from the register, not combinationally from p.
  - On shift_en=1 with counter<WIDTH-1: shift by one toward the output end, fill with 0, counter++.
  - On shift_en=1 with counter==WIDTH-1: go to IDLE (or PARITY when enabled), and assert done=1 for exactly one cycle if going to IDLE.
  - shift_en=0: hold the current bit and counter indefinitely.
- Latency:
  - Load accepted at edge N; first bit is visible in cycle N+1.
  - With shift_en tied high, bit k occupies cycle N+1+k.
  - done, load_ready=1 and IDLE_LEVEL appear in cycle N+1+WIDTH.
- load_valid while load_ready=0 is ignored; p is not sampled.
- Back-to-back words: a word can be accepted on the edge that ends the done cycle, giving exactly one idle cycle between words.
- The counter width is clog2(WIDTH). No wrap beyond WIDTH-1 is possible.
- done is registered and never asserted in IDLE except the single cycle after completion.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined:
  - Even parity of the captured word is computed at load and stored.
  - After the last data bit, the FSM enters state PARITY: serial_out=parity, serial_valid=1, busy=1, load_ready=0.
  - The next shift_en=1 moves to IDLE with the done pulse.
  - A word takes WIDTH+1 ticks.
  - Reset clears the parity bit.
- Undefined: no PARITY state or parity register exists, and timing is as described in Behaviour.

Test Plan:
1. rst=0 for 2 edges with load_valid=1, p=8'hFF → load_ready=1, serial_out=0, serial_valid=0, busy=0, done=0, and no load taken.
2. WIDTH=8, MSB_FIRST=1, shift_en=1, load 8'hA5 → serial_out 1,0,1,0,0,1,0,1 in cycles 1..8 with serial_valid=1; done=1 only in cycle 9.
3. MSB_FIRST=0, load 8'hA5 → serial_out 1,0,1,0,0,1,0,1 reversed by bit order, i.e. 1,0,1,0,0,1,0,1 read from bit 0: 1,0,1,0,0,1,0,1 → check it equals p[0..7] = 1,0,1,0,0,1,0,1; repeat with 8'h01 → 1 then seven 0s.
4. shift_en pulsed every 4th cycle, load 8'hC3 → each bit held exactly 4 cycles; done after 32 cycles; load_valid=1 with p=8'h00 mid-word is ignored and output stays 8'hC3's sequence.
5. Reset asserted after bit 3 of 8'hF0 → next cycle serial_out=IDLE_LEVEL, busy=0, no done; a subsequent load of 8'h0F transmits cleanly.
6. PISO_PARITY_EN defined, load 8'h07 → 8 data bits then parity bit=1, done in cycle 10; load 8'h03 → parity bit=0.

Source files
------------

// File: rtl/piso_shift_reg_param.sv
// Parametrised parallel-in/serial-out shift register with valid/ready load and shift tick.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of every word.
module piso_shift_reg_param #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] p,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t           state, state_next;
   logic [WIDTH-1:0] shreg, shreg_next, shreg_shifted;
   logic [CW-1:0]    count, count_next;
   logic             done_next;
   logic             head_bit;
`ifdef PISO_PARITY_EN
   logic             parity, parity_next;
`endif

   // The bit on the wire always comes from the register end nearest the output.
   assign head_bit      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
   assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         shreg <= '0;
         count <= '0;
         done  <= 1'b0;
`ifdef PISO_PARITY_EN
         parity <= 1'b0;
`endif
      end else begin
         state <= state_next;
         shreg <= shreg_next;
         count <= count_next;
         done  <= done_next;
`ifdef PISO_PARITY_EN
         parity <= parity_next;
`endif
      end
   end

   always_comb begin
      state_next   = state;
      shreg_next   = shreg;
      count_next   = count;
      done_next    = 1'b0;
`ifdef PISO_PARITY_EN
      parity_next  = parity;
`endif
      load_ready   = 1'b0;
      busy         = 1'b0;
      serial_valid = 1'b0;
      serial_out   = IDLE_LEVEL;

      case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               shreg_next = p;
               count_next = '0;
`ifdef PISO_PARITY_EN
               parity_next = ^p;
`endif
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy         = 1'b1;
            serial_valid = 1'b1;
            serial_out   = head_bit;
            if (shift_en) begin
               if (count == LAST) begin
`ifdef PISO_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = IDLE;
                  done_next  = 1'b1;
`endif
               end else begin
                  shreg_next = shreg_shifted;
                  count_next = count + CW'(1);
               end
            end
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            busy         = 1'b1;
            serial_valid = 1'b1;
            serial_out   = parity;
            if (shift_en) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

endmodule
